store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port st_valid  input  1  Execute presents a store this cycle.
REQ-005 SHALL have port st_addr  input  32  byte address of the store (ALU result).
REQ-006 SHALL have port st_data  input  32  unaligned store data (rs2); low byte or half is significant.
REQ-007 SHALL have port st_sel  input  2  store size: 00=SB, 01=SH, 10=SW, 11=illegal.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port mem_req_valid  output  1  head entry presented to data memory.
REQ-010 SHALL have port mem_addr  output  32  word-aligned write address; bits [1:0] always 00.
REQ-011 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-012 SHALL have port mem_we  output  4  byte write enables; bit i enables byte lane i.
REQ-013 SHALL have port mem_req_ready  input  1  memory accepts the head entry this cycle.
REQ-014 SHALL have port ld_addr  input  32  byte address of a load in Execute.
REQ-015 SHALL have port ld_hazard  output  1  pending store overlaps the load's word.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse: a store was dropped.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL accept (enqueue) a store when st_valid && st_ready; st_ready = (count < DEPTH) && !rst, with no dependence on mem_req_ready.
REQ-019 SHALL align stores before enqueue:
- SB: wdata = {4{st_data[7:0]}}, we = 4'b0001 << st_addr[1:0].
- SH: wdata = {2{st_data[15:0]}}, we = st_addr[1] ? 4'b1100 : 4'b0011.
- SW: wdata = st_data, we = 4'b1111.
- mem_addr = {st_addr[31:2], 2'b00}.
REQ-020 SHALL drop, without enqueuing, an accepted store that is:
- SH with st_addr[0] = 1,
- SW with st_addr[1:0] != 00, or
- st_sel = 11.
Count is unchanged, and misalign is asserted for exactly the next cycle.
REQ-021 SHALL drain entries strictly in FIFO order; the head is dequeued when mem_req_valid && mem_req_ready.
REQ-022 SHALL drive mem_req_valid = (count != 0), with mem_addr/mem_wdata/mem_we taken from the head entry held in registers.
REQ-023 SHALL hold mem_addr/mem_wdata/mem_we stable while mem_req_valid && !mem_req_ready.
REQ-024 SHALL present a store accepted in cycle N on the mem_req outputs no earlier than cycle N+1; there is no combinational pass-through.
REQ-025 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
- When full, enqueue is blocked even if a dequeue occurs in the same cycle.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL keep full and empty unambiguous via count.
REQ-028 SHALL assert ld_hazard combinationally when ld_addr[31:2] equals the word address of any occupied entry, or of a legal store being accepted that same cycle.
- An entry dequeued in the current cycle still counts toward ld_hazard.
REQ-029 SHALL ignore mem_req_ready when count = 0.
REQ-030 SHALL ignore st_valid when st_ready = 0; the store is not captured and misalign is not pulsed.

Reset
REQ-031 SHALL, in the cycle after rst is sampled high, have:
- count = 0, both pointers = 0;
- mem_req_valid = 0, misalign = 0, ld_hazard = 0 (unless a same-cycle store is accepted);
- st_ready = 1 once rst is low.
REQ-032 SHALL, on rst asserted mid-operation, discard all pending entries.
- No write completes after the reset edge.
- Entry data contents need not be cleared.

Verification
REQ-033 SHALL pass: SB st_addr=0x1003, st_data=0x000000AB, mem_req_ready=1 -> next cycle mem_addr=0x1000, mem_wdata=0xABABABAB, mem_we=1000; then count returns to 0.
REQ-034 SHALL pass: 5 back-to-back SW (0x0,0x4,0x8,0xC,0x10), mem_req_ready=0 -> st_ready falls after 4th accept, count=4; release ready -> writes emerge in order 0x0..0xC, then 0x10 is accepted on retry.
REQ-035 SHALL pass: SH at 0x2001 -> not enqueued, misalign=1 for one cycle, count stays 0; SW at 0x2002 -> same.
REQ-036 SHALL pass: SW 0x40 pending with ready=0, ld_addr=0x43 -> ld_hazard=1; ld_addr=0x44 -> ld_hazard=0.
REQ-037 SHALL pass: full buffer with ready=1 and st_valid=1 -> one dequeue, no enqueue, count=3; next cycle enqueue plus dequeue -> count=3.
REQ-038 SHALL pass: 3 entries pending, rst pulsed 1 cycle -> mem_req_valid=0, count=0 next cycle, no further mem_we activity.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns Execute stores into byte lanes and queues them
// for data memory in FIFO order, with load-overlap hazard detection.
module store_write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st_valid,
   input  logic [31:0]            st_addr,
   input  logic [31:0]            st_data,
   input  logic [1:0]             st_sel,
   output logic                   st_ready,
   output logic                   mem_req_valid,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   output logic [3:0]             mem_we,
   input  logic                   mem_req_ready,
   input  logic [31:0]            ld_addr,
   output logic                   ld_hazard,
   output logic                   misalign,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [29:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [3:0]    we_q   [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          misalign_q;

   logic          accept;
   logic          legal;
   logic          enq;
   logic          deq;
   logic [31:0]   al_data;
   logic [3:0]    al_we;
   logic [AW-1:0] off;
   logic          hit;
   logic          unused_ld;

   assign unused_ld = ^ld_addr[1:0];

   always_comb begin
      al_data = st_data;
      al_we   = 4'b0000;
      legal   = 1'b0;
      unique case (st_sel)
         2'b00: begin
            al_data = {4{st_data[7:0]}};
            al_we   = 4'b0001 << st_addr[1:0];
            legal   = 1'b1;
         end
         2'b01: begin
            al_data = {2{st_data[15:0]}};
            al_we   = st_addr[1] ? 4'b1100 : 4'b0011;
            legal   = !st_addr[0];
         end
         2'b10: begin
            al_data = st_data;
            al_we   = 4'b1111;
            legal   = (st_addr[1:0] == 2'b00);
         end
         default: begin
            legal   = 1'b0;
         end
      endcase
   end

   assign st_ready = (cnt_q < CW'(DEPTH)) && !rst;
   assign accept   = st_valid && st_ready;
   assign enq      = accept && legal;
   assign deq      = mem_req_valid && mem_req_ready;

   assign mem_req_valid = (cnt_q != '0);
   assign mem_addr      = {addr_q[rd_ptr], 2'b00};
   assign mem_wdata     = data_q[rd_ptr];
   assign mem_we        = mem_req_valid ? we_q[rd_ptr] : 4'b0000;
   assign misalign      = misalign_q;
   assign count         = cnt_q;

   // An entry is occupied when its distance from the head is below count.
   always_comb begin
      hit = enq && (st_addr[31:2] == ld_addr[31:2]);
      off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr;
         if (({1'b0, off} < cnt_q) && (addr_q[i] == ld_addr[31:2]))
            hit = 1'b1;
      end
   end

   assign ld_hazard = hit;

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[wr_ptr] <= st_addr[31:2];
         data_q[wr_ptr] <= al_data;
         we_q[wr_ptr]   <= al_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         misalign_q <= accept && !legal;
      end
   end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed testbench for store_write_buffer (DEPTH=4): alignment, FIFO
// drain, misalign drops, load hazards, full behaviour and mid-run reset.
module tb_store_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_sel;
   logic        st_ready;
   logic        mem_req_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic        mem_req_ready;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic        misalign;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   store_write_buffer #(.DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .st_valid      (st_valid),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_sel        (st_sel),
      .st_ready      (st_ready),
      .mem_req_valid (mem_req_valid),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_we        (mem_we),
      .mem_req_ready (mem_req_ready),
      .ld_addr       (ld_addr),
      .ld_hazard     (ld_hazard),
      .misalign      (misalign),
      .count         (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [1:0] sel, input logic [31:0] a,
                      input logic [31:0] d);
      st_valid = 1'b1;
      st_sel   = sel;
      st_addr  = a;
      st_data  = d;
   endtask

   initial begin
      rst           = 1'b1;
      st_valid      = 1'b0;
      st_addr       = '0;
      st_data       = '0;
      st_sel        = 2'b00;
      mem_req_ready = 1'b0;
      ld_addr       = 32'hFFFF_FFF0;

      tick();
      tick();
      chk("rdy_in_rst", 32'(st_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_misal", 32'(misalign), 32'd0);
      chk("rst_haz", 32'(ld_hazard), 32'd0);
      chk("rst_rdy", 32'(st_ready), 32'd1);

      // empty buffer ignores mem_req_ready
      mem_req_ready = 1'b1;
      tick();
      chk("empty_cnt", 32'(count), 32'd0);

      // SB at 0x1003
      put(2'b00, 32'h0000_1003, 32'h0000_00AB);
      ld_addr = 32'h0000_1000;
      #1;
      chk("sb_haz_same", 32'(ld_hazard), 32'd1);
      chk("sb_no_pass", 32'(mem_req_valid), 32'd0);
      tick();
      st_valid = 1'b0;
      #1;
      chk("sb_valid", 32'(mem_req_valid), 32'd1);
      chk("sb_addr", mem_addr, 32'h0000_1000);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_we", 32'(mem_we), 32'h8);
      tick();
      chk("sb_drain", 32'(count), 32'd0);
      chk("sb_novalid", 32'(mem_req_valid), 32'd0);

      // five back-to-back SW with memory stalled
      mem_req_ready = 1'b0;
      ld_addr = 32'hFFFF_FFF0;
      for (int i = 0; i < 5; i++) begin
         put(2'b10, 32'(4 * i), 32'h100 + 32'(i));
         #1;
         chk($sformatf("sw_rdy%0d", i), 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      chk("full_cnt", 32'(count), 32'd4);
      chk("hold_addr", mem_addr, 32'h0);
      chk("hold_wdata", mem_wdata, 32'h100);
      put(2'b11, 32'h0, 32'h0);
      tick();
      chk("full_nomis", 32'(misalign), 32'd0);
      chk("full_cnt2", 32'(count), 32'd4);
      chk("stable_addr", mem_addr, 32'h0);
      chk("stable_we", 32'(mem_we), 32'hF);

      // release: dequeue while full blocks enqueue, then 0x10 retries
      put(2'b10, 32'h10, 32'h104);
      mem_req_ready = 1'b1;
      tick();
      chk("fd_cnt", 32'(count), 32'd3);
      chk("fd_addr", mem_addr, 32'h4);
      tick();
      st_valid = 1'b0;
      #1;
      chk("ed_cnt", 32'(count), 32'd3);
      chk("ed_addr", mem_addr, 32'h8);
      tick();
      chk("d3_addr", mem_addr, 32'hC);
      tick();
      chk("d4_addr", mem_addr, 32'h10);
      chk("d4_wdata", mem_wdata, 32'h104);
      tick();
      chk("d5_cnt", 32'(count), 32'd0);

      // misaligned drops
      mem_req_ready = 1'b0;
      put(2'b01, 32'h2001, 32'h1234);
      ld_addr = 32'h2000;
      #1;
      chk("mis_haz", 32'(ld_hazard), 32'd0);
      tick();
      st_valid = 1'b0;
      #1;
      chk("sh_mis", 32'(misalign), 32'd1);
      chk("sh_cnt", 32'(count), 32'd0);
      tick();
      chk("sh_mis_end", 32'(misalign), 32'd0);
      put(2'b10, 32'h2002, 32'h5555);
      tick();
      st_valid = 1'b0;
      #1;
      chk("sw_mis", 32'(misalign), 32'd1);
      chk("sw_cnt", 32'(count), 32'd0);
      tick();
      chk("sw_mis_end", 32'(misalign), 32'd0);
      put(2'b11, 32'h3000, 32'h0);
      tick();
      st_valid = 1'b0;
      #1;
      chk("sel11_mis", 32'(misalign), 32'd1);
      chk("sel11_cnt", 32'(count), 32'd0);

      // load hazards and lane alignment of SW/SB/SH
      put(2'b10, 32'h40, 32'h1122_3344);
      tick();
      put(2'b00, 32'h45, 32'h0000_0077);
      tick();
      put(2'b01, 32'h2002, 32'hDEAD_1234);
      tick();
      st_valid = 1'b0;
      ld_addr = 32'h43;
      #1;
      chk("haz_43", 32'(ld_hazard), 32'd1);
      ld_addr = 32'h48;
      #1;
      chk("haz_48", 32'(ld_hazard), 32'd0);
      ld_addr = 32'h2003;
      #1;
      chk("haz_2003", 32'(ld_hazard), 32'd1);
      chk("h0_we", 32'(mem_we), 32'hF);
      chk("h0_wdata", mem_wdata, 32'h1122_3344);
      mem_req_ready = 1'b1;
      ld_addr = 32'h40;
      #1;
      chk("haz_deq", 32'(ld_hazard), 32'd1);
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("haz_gone", 32'(ld_hazard), 32'd0);
      chk("h1_addr", mem_addr, 32'h44);
      chk("h1_we", 32'(mem_we), 32'h2);
      chk("h1_wdata", mem_wdata, 32'h7777_7777);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("h2_addr", mem_addr, 32'h2000);
      chk("h2_we", 32'(mem_we), 32'hC);
      chk("h2_wdata", mem_wdata, 32'h1234_1234);

      // mid-run reset with three pending entries
      put(2'b10, 32'h80, 32'h8);
      tick();
      put(2'b10, 32'h84, 32'h9);
      tick();
      st_valid = 1'b0;
      #1;
      chk("pre_rst_cnt", 32'(count), 32'd3);
      rst = 1'b1;
      mem_req_ready = 1'b1;
      tick();
      rst = 1'b0;
      ld_addr = 32'h80;
      #1;
      chk("mr_cnt", 32'(count), 32'd0);
      chk("mr_valid", 32'(mem_req_valid), 32'd0);
      chk("mr_we", 32'(mem_we), 32'h0);
      chk("mr_haz", 32'(ld_hazard), 32'd0);
      chk("mr_rdy", 32'(st_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mr_we%0d", i), 32'(mem_we), 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
